// File: rtl/axi_cmd_arbiter_if.sv
// Interface bundle for the AXI address-channel command arbiter: AW/AR request channels,
// the registered command stage toward the DDR2 scheduler, and completion/occupancy signals.
interface axi_cmd_arbiter_if #(
   parameter int ADDR_WIDTH      = 32,
   parameter int ID_WIDTH        = 4,
   parameter int ADDR_LEN        = 4,
   parameter int MAX_OUTSTANDING = 4
) ();
   localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

   logic                  aw_avalid;
   logic [ID_WIDTH-1:0]   aw_aid;
   logic [ADDR_WIDTH-1:0] aw_aaddr;
   logic [ADDR_LEN-1:0]   aw_alen;
   logic [2:0]            aw_asize;
   logic [1:0]            aw_aburst;
   logic                  aw_aready;

   logic                  ar_avalid;
   logic [ID_WIDTH-1:0]   ar_aid;
   logic [ADDR_WIDTH-1:0] ar_aaddr;
   logic [ADDR_LEN-1:0]   ar_alen;
   logic [2:0]            ar_asize;
   logic [1:0]            ar_aburst;
   logic                  ar_aready;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ID_WIDTH-1:0]   cmd_id;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [ADDR_LEN-1:0]   cmd_len;
   logic [2:0]            cmd_size;
   logic [1:0]            cmd_burst;

   logic                  wr_done;
   logic                  rd_done;
   logic [CNT_WIDTH-1:0]  wr_outstanding;
   logic [CNT_WIDTH-1:0]  rd_outstanding;

   // The arbiter side: accepts AXI address requests, drives the command stage.
   modport slave (
      input  aw_avalid, aw_aid, aw_aaddr, aw_alen, aw_asize, aw_aburst,
      output aw_aready,
      input  ar_avalid, ar_aid, ar_aaddr, ar_alen, ar_asize, ar_aburst,
      output ar_aready,
      output cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
      input  cmd_ready,
      input  wr_done, rd_done,
      output wr_outstanding, rd_outstanding
   );

   // The environment side: AXI master plus the DDR2 scheduler and completion logic.
   modport master (
      output aw_avalid, aw_aid, aw_aaddr, aw_alen, aw_asize, aw_aburst,
      input  aw_aready,
      output ar_avalid, ar_aid, ar_aaddr, ar_alen, ar_asize, ar_aburst,
      input  ar_aready,
      input  cmd_valid, cmd_write, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
      output cmd_ready,
      output wr_done, rd_done,
      input  wr_outstanding, rd_outstanding
   );
endinterface

// File: rtl/axi_cmd_arbiter.sv
// Arbitrates AXI AW and AR address requests onto one registered DDR2 command stage,
// with read priority, a bounded read streak, and per-direction outstanding limits.
module axi_cmd_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int ID_WIDTH        = 4,
   parameter int ADDR_LEN        = 4,
   parameter int MAX_OUTSTANDING = 4,
   parameter int RD_STREAK_MAX   = 4
) (
   input logic              clk,
   input logic              rst,
   axi_cmd_arbiter_if.slave bus
);
   localparam int CNT_WIDTH    = $clog2(MAX_OUTSTANDING + 1);
   localparam int STREAK_WIDTH = $clog2(RD_STREAK_MAX + 1);
   localparam logic [CNT_WIDTH-1:0]    CNT_MAX    = CNT_WIDTH'(MAX_OUTSTANDING);
   localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(RD_STREAK_MAX);

   typedef enum logic [1:0] {
      GRANT_NONE,
      GRANT_RD,
      GRANT_WR
   } grant_t;

   logic                    r_cmdValid;
   logic                    r_cmdWrite;
   logic [ID_WIDTH-1:0]     r_cmdId;
   logic [ADDR_WIDTH-1:0]   r_cmdAddr;
   logic [ADDR_LEN-1:0]     r_cmdLen;
   logic [2:0]              r_cmdSize;
   logic [1:0]              r_cmdBurst;
   logic [CNT_WIDTH-1:0]    r_wrOut;
   logic [CNT_WIDTH-1:0]    r_rdOut;
   logic [STREAK_WIDTH-1:0] r_streak;

   logic                    w_loadEn;
   logic                    w_wrElig;
   logic                    w_rdElig;
   grant_t                  w_grant;
   logic                    w_awHs;
   logic                    w_arHs;
   logic                    w_wrDec;
   logic                    w_rdDec;
   logic [CNT_WIDTH-1:0]    w_wrOutNext;
   logic [CNT_WIDTH-1:0]    w_rdOutNext;
   logic [STREAK_WIDTH-1:0] w_streakNext;

   // Eligibility uses registered counts, so a completion never unblocks its own cycle.
   always_comb begin
      w_loadEn = !r_cmdValid || bus.cmd_ready;
      w_wrElig = bus.aw_avalid && (r_wrOut < CNT_MAX);
      w_rdElig = bus.ar_avalid && (r_rdOut < CNT_MAX);
   end

   always_comb begin
      w_grant = GRANT_NONE;
      if (w_loadEn && !rst) begin
         if (w_rdElig && w_wrElig) begin
            w_grant = (r_streak == STREAK_MAX) ? GRANT_WR : GRANT_RD;
         end else if (w_rdElig) begin
            w_grant = GRANT_RD;
         end else if (w_wrElig) begin
            w_grant = GRANT_WR;
         end
      end
   end

   assign w_awHs        = (w_grant == GRANT_WR);
   assign w_arHs        = (w_grant == GRANT_RD);
   assign bus.aw_aready = w_awHs;
   assign bus.ar_aready = w_arHs;

   // The streak only grows while a write is actually competing; a full write side freezes it.
   always_comb begin
      w_streakNext = r_streak;
      case (w_grant)
         GRANT_WR: w_streakNext = '0;
         GRANT_RD: begin
            if (!bus.aw_avalid) begin
               w_streakNext = '0;
            end else if (w_wrElig && (r_streak != STREAK_MAX)) begin
               w_streakNext = r_streak + 1'b1;
            end
         end
         default: w_streakNext = r_streak;
      endcase
   end

   always_comb begin
      w_wrDec     = bus.wr_done && (r_wrOut != '0);
      w_rdDec     = bus.rd_done && (r_rdOut != '0);
      w_wrOutNext = r_wrOut;
      w_rdOutNext = r_rdOut;
      case ({w_awHs, w_wrDec})
         2'b10:   w_wrOutNext = r_wrOut + 1'b1;
         2'b01:   w_wrOutNext = r_wrOut - 1'b1;
         default: w_wrOutNext = r_wrOut;
      endcase
      case ({w_arHs, w_rdDec})
         2'b10:   w_rdOutNext = r_rdOut + 1'b1;
         2'b01:   w_rdOutNext = r_rdOut - 1'b1;
         default: w_rdOutNext = r_rdOut;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrOut  <= '0;
         r_rdOut  <= '0;
         r_streak <= '0;
      end else begin
         r_wrOut  <= w_wrOutNext;
         r_rdOut  <= w_rdOutNext;
         r_streak <= w_streakNext;
      end
   end

   // Command stage refills in the cycle it drains; it is frozen while the scheduler stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cmdValid <= 1'b0;
         r_cmdWrite <= 1'b0;
         r_cmdId    <= '0;
         r_cmdAddr  <= '0;
         r_cmdLen   <= '0;
         r_cmdSize  <= '0;
         r_cmdBurst <= '0;
      end else if (w_loadEn) begin
         case (w_grant)
            GRANT_WR: begin
               r_cmdValid <= 1'b1;
               r_cmdWrite <= 1'b1;
               r_cmdId    <= bus.aw_aid;
               r_cmdAddr  <= bus.aw_aaddr;
               r_cmdLen   <= bus.aw_alen;
               r_cmdSize  <= bus.aw_asize;
               r_cmdBurst <= bus.aw_aburst;
            end
            GRANT_RD: begin
               r_cmdValid <= 1'b1;
               r_cmdWrite <= 1'b0;
               r_cmdId    <= bus.ar_aid;
               r_cmdAddr  <= bus.ar_aaddr;
               r_cmdLen   <= bus.ar_alen;
               r_cmdSize  <= bus.ar_asize;
               r_cmdBurst <= bus.ar_aburst;
            end
            default: r_cmdValid <= 1'b0;
         endcase
      end
   end

   assign bus.cmd_valid      = r_cmdValid;
   assign bus.cmd_write      = r_cmdWrite;
   assign bus.cmd_id         = r_cmdId;
   assign bus.cmd_addr       = r_cmdAddr;
   assign bus.cmd_len        = r_cmdLen;
   assign bus.cmd_size       = r_cmdSize;
   assign bus.cmd_burst      = r_cmdBurst;
   assign bus.wr_outstanding = r_wrOut;
   assign bus.rd_outstanding = r_rdOut;

`ifndef SYNTHESIS
   // A completion with nothing in flight means the upstream response logic is broken.
   wrDoneAtZero : assert property (@(posedge clk) disable iff (rst) !(bus.wr_done && (r_wrOut == '0)));
   rdDoneAtZero : assert property (@(posedge clk) disable iff (rst) !(bus.rd_done && (r_rdOut == '0)));
   oneReady     : assert property (@(posedge clk) !(bus.aw_aready && bus.ar_aready));
`endif

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Scoreboard bench for axi_cmd_arbiter: directed AW/AR traffic pushes expected commands,
// a negedge monitor pops and compares every command the scheduler accepts.
module tb_axi_cmd_arbiter;
   logic clk;
   logic rst;

   axi_cmd_arbiter_if #(.ADDR_WIDTH(32), .ID_WIDTH(4), .ADDR_LEN(4), .MAX_OUTSTANDING(4)) bus ();

   axi_cmd_arbiter #(
      .ADDR_WIDTH(32), .ID_WIDTH(4), .ADDR_LEN(4), .MAX_OUTSTANDING(4), .RD_STREAK_MAX(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic        wr;
      logic [3:0]  id;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } cmd_t;

   cmd_t expQ[$];
   int   testsRun;
   int   testsFailed;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Writes use size 3 / INCR, reads size 2 / WRAP so a swapped capture is visible.
   function automatic cmd_t mkCmd(input logic wr, input logic [3:0] id, input logic [31:0] addr,
                                  input logic [3:0] len);
      cmd_t c;
      c.wr    = wr;
      c.id    = id;
      c.addr  = addr;
      c.len   = len;
      c.size  = wr ? 3'd3 : 3'd2;
      c.burst = wr ? 2'b01 : 2'b10;
      return c;
   endfunction

   task automatic setAw(input logic v, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
      bus.aw_avalid = v;
      bus.aw_aid    = id;
      bus.aw_aaddr  = addr;
      bus.aw_alen   = len;
      bus.aw_asize  = 3'd3;
      bus.aw_aburst = 2'b01;
   endtask

   task automatic setAr(input logic v, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
      bus.ar_avalid = v;
      bus.ar_aid    = id;
      bus.ar_aaddr  = addr;
      bus.ar_alen   = len;
      bus.ar_asize  = 3'd2;
      bus.ar_aburst = 2'b10;
   endtask

   task automatic applyStimulus(input logic cmdReady, input logic wrDone, input logic rdDone);
      bus.cmd_ready = cmdReady;
      bus.wr_done   = wrDone;
      bus.rd_done   = rdDone;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted command must match the oldest expected one.
   always @(negedge clk) begin
      if (!rst && bus.cmd_valid && bus.cmd_ready) begin
         cmd_t got;
         got = {bus.cmd_write, bus.cmd_id, bus.cmd_addr, bus.cmd_len, bus.cmd_size, bus.cmd_burst};
         if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected_cmd: got 0x%0h, expected no command", got);
         end else begin
            cmd_t exp;
            exp = expQ.pop_front();
            checkOutput("scoreboard_cmd", 64'(got), 64'(exp));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  wc;
      int  rc;
      logic pendW;
      logic pendR;
      logic isW;

      testsRun    = 0;
      testsFailed = 0;
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      setAw(1'b1, 4'h1, 32'hAAAA_0000, 4'h1);
      setAr(1'b1, 4'h2, 32'hBBBB_0000, 4'h2);

      // Reset: readies held low even with requests pending.
      nextCycle();
      @(negedge clk);
      checkOutput("rst_aw_aready", 64'(bus.aw_aready), 64'd0);
      checkOutput("rst_ar_aready", 64'(bus.ar_aready), 64'd0);
      nextCycle();
      rst = 1'b0;
      setAw(1'b0, 4'h0, 32'h0, 4'h0);
      setAr(1'b0, 4'h0, 32'h0, 4'h0);
      @(negedge clk);
      checkOutput("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
      checkOutput("rst_cmd_addr", 64'(bus.cmd_addr), 64'd0);
      checkOutput("rst_wr_out", 64'(bus.wr_outstanding), 64'd0);
      checkOutput("rst_rd_out", 64'(bus.rd_outstanding), 64'd0);

      // Single read.
      nextCycle();
      setAr(1'b1, 4'd3, 32'h100, 4'd7);
      @(negedge clk);
      checkOutput("single_ar_aready", 64'(bus.ar_aready), 64'd1);
      checkOutput("single_aw_aready", 64'(bus.aw_aready), 64'd0);
      expQ.push_back(mkCmd(1'b0, 4'd3, 32'h100, 4'd7));
      nextCycle();
      setAr(1'b0, 4'd0, 32'h0, 4'd0);
      @(negedge clk);
      checkOutput("single_cmd_valid", 64'(bus.cmd_valid), 64'd1);
      checkOutput("single_rd_out", 64'(bus.rd_outstanding), 64'd1);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("single_drain_valid", 64'(bus.cmd_valid), 64'd0);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("single_rd_out_back", 64'(bus.rd_outstanding), 64'd0);

      // Streak limit: both channels always requesting, expect R,R,R,R,W,R,R,R,R,W.
      wc = 0;
      rc = 0;
      pendW = 1'b0;
      pendR = 1'b0;
      for (int i = 0; i < 10; i++) begin
         nextCycle();
         setAw(1'b1, 4'(wc + 1), 32'h1000 + 32'(wc * 16), 4'(wc));
         setAr(1'b1, 4'(rc), 32'h2000 + 32'(rc * 16), 4'd3);
         applyStimulus(1'b1, pendW, pendR);
         isW = ((i % 5) == 4);
         @(negedge clk);
         checkOutput("streak_aw_aready", 64'(bus.aw_aready), 64'(isW));
         if (isW) begin
            expQ.push_back(mkCmd(1'b1, 4'(wc + 1), 32'h1000 + 32'(wc * 16), 4'(wc)));
            wc++;
         end else begin
            expQ.push_back(mkCmd(1'b0, 4'(rc), 32'h2000 + 32'(rc * 16), 4'd3));
            rc++;
         end
         pendW = isW;
         pendR = !isW;
      end
      nextCycle();
      setAw(1'b0, 4'h0, 32'h0, 4'h0);
      setAr(1'b0, 4'h0, 32'h0, 4'h0);
      applyStimulus(1'b1, pendW, pendR);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("streak_wr_out", 64'(bus.wr_outstanding), 64'd0);
      checkOutput("streak_rd_out", 64'(bus.rd_outstanding), 64'd0);

      // Backpressure: loaded command holds, readies drop, release accepts in same cycle.
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0);
      setAr(1'b1, 4'd5, 32'h300, 4'd2);
      @(negedge clk);
      checkOutput("bp_first_ar_aready", 64'(bus.ar_aready), 64'd1);
      expQ.push_back(mkCmd(1'b0, 4'd5, 32'h300, 4'd2));
      nextCycle();
      setAr(1'b1, 4'd6, 32'h340, 4'd1);
      setAw(1'b1, 4'd9, 32'h400, 4'd4);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checkOutput("bp_aw_aready", 64'(bus.aw_aready), 64'd0);
         checkOutput("bp_ar_aready", 64'(bus.ar_aready), 64'd0);
         checkOutput("bp_cmd_addr", 64'(bus.cmd_addr), 64'h300);
         checkOutput("bp_cmd_id", 64'(bus.cmd_id), 64'd5);
         nextCycle();
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("bp_release_ar_aready", 64'(bus.ar_aready), 64'd1);
      expQ.push_back(mkCmd(1'b0, 4'd6, 32'h340, 4'd1));
      nextCycle();
      setAr(1'b0, 4'h0, 32'h0, 4'h0);
      @(negedge clk);
      checkOutput("bp_then_aw_aready", 64'(bus.aw_aready), 64'd1);
      expQ.push_back(mkCmd(1'b1, 4'd9, 32'h400, 4'd4));

      // Simultaneous AR handshake and rd_done at rd_outstanding=2.
      nextCycle();
      setAw(1'b0, 4'h0, 32'h0, 4'h0);
      setAr(1'b1, 4'd7, 32'h500, 4'd0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("sim_rd_out_before", 64'(bus.rd_outstanding), 64'd2);
      checkOutput("sim_ar_aready", 64'(bus.ar_aready), 64'd1);
      expQ.push_back(mkCmd(1'b0, 4'd7, 32'h500, 4'd0));
      nextCycle();
      setAr(1'b0, 4'h0, 32'h0, 4'h0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("sim_rd_out_after", 64'(bus.rd_outstanding), 64'd2);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b1);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b1);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("sim_clean_wr_out", 64'(bus.wr_outstanding), 64'd0);
      checkOutput("sim_clean_rd_out", 64'(bus.rd_outstanding), 64'd0);

      // Outstanding limit: four writes fill the write side; reads still flow.
      for (int k = 0; k < 4; k++) begin
         nextCycle();
         setAw(1'b1, 4'(k), 32'h600 + 32'(k * 16), 4'd1);
         @(negedge clk);
         checkOutput("lim_fill_aw_aready", 64'(bus.aw_aready), 64'd1);
         expQ.push_back(mkCmd(1'b1, 4'(k), 32'h600 + 32'(k * 16), 4'd1));
      end
      nextCycle();
      setAw(1'b1, 4'd4, 32'h640, 4'd1);
      setAr(1'b1, 4'hA, 32'h700, 4'd5);
      @(negedge clk);
      checkOutput("lim_wr_out_full", 64'(bus.wr_outstanding), 64'd4);
      checkOutput("lim_full_aw_aready", 64'(bus.aw_aready), 64'd0);
      checkOutput("lim_full_ar_aready", 64'(bus.ar_aready), 64'd1);
      expQ.push_back(mkCmd(1'b0, 4'hA, 32'h700, 4'd5));
      nextCycle();
      setAr(1'b0, 4'h0, 32'h0, 4'h0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("lim_done_same_cycle_aw_aready", 64'(bus.aw_aready), 64'd0);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("lim_wr_out_after_done", 64'(bus.wr_outstanding), 64'd3);
      checkOutput("lim_unblocked_aw_aready", 64'(bus.aw_aready), 64'd1);
      expQ.push_back(mkCmd(1'b1, 4'd4, 32'h640, 4'd1));

      // Reset mid-operation with a stalled command and nonzero counters.
      nextCycle();
      setAw(1'b0, 4'h0, 32'h0, 4'h0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("mid_cmd_valid", 64'(bus.cmd_valid), 64'd1);
      checkOutput("mid_cmd_addr", 64'(bus.cmd_addr), 64'h640);
      checkOutput("mid_wr_out", 64'(bus.wr_outstanding), 64'd4);
      checkOutput("mid_rd_out", 64'(bus.rd_outstanding), 64'd1);
      nextCycle();
      rst = 1'b1;
      setAw(1'b1, 4'd1, 32'h800, 4'd0);
      setAr(1'b1, 4'd2, 32'h900, 4'd0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      void'(expQ.pop_back());
      @(negedge clk);
      checkOutput("mid_rst_aw_aready", 64'(bus.aw_aready), 64'd0);
      checkOutput("mid_rst_ar_aready", 64'(bus.ar_aready), 64'd0);
      nextCycle();
      rst = 1'b0;
      setAw(1'b0, 4'h0, 32'h0, 4'h0);
      setAr(1'b0, 4'h0, 32'h0, 4'h0);
      @(negedge clk);
      checkOutput("post_rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
      checkOutput("post_rst_wr_out", 64'(bus.wr_outstanding), 64'd0);
      checkOutput("post_rst_rd_out", 64'(bus.rd_outstanding), 64'd0);

      nextCycle();
      @(negedge clk);
      checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
